// File: rtl/cv32e40p_nmr_pkg.sv
// Shared types and constants for the NMR word voter and its per-replica
// health trackers.
package cv32e40p_nmr_pkg;

  // Redundancy level, derived from the number of healthy replicas
  typedef enum logic [1:0] {
    NMR     = 2'b00,
    DUPLEX  = 2'b01,
    SIMPLEX = 2'b10
  } mode_e;

  // Per-replica health state
  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAULTY  = 2'b10
  } health_e;

  // Width of the optional correction / uncorrectable beat totals
  localparam int STATS_W = 16;

endpackage

// File: rtl/cv32e40p_nmr_health.sv
// Health tracker for one replica: counts consecutive mismatching beats and
// takes the replica out of the vote once the count reaches FAULT_THRESH.
// A FAULTY replica only comes back through reinstate.
module cv32e40p_nmr_health
  import cv32e40p_nmr_pkg::*;
#(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mismatch,
  input  logic beat_en,
  input  logic reinstate,
  input  logic exclude_allow,
  output logic healthy
);

  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  health_e          state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  // State and consecutive-mismatch counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HEALTHY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
    end
  end

  // Next state: reinstate wins over everything, otherwise only counted beats move the FSM
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    if (reinstate) begin
      state_next = HEALTHY;
      cnt_next   = '0;
    end else if (beat_en) begin
      case (state_q)
        HEALTHY: begin
          if (mismatch) begin
            cnt_next   = cnt_inc;
            state_next = (cnt_inc >= THRESH && exclude_allow) ? FAULTY : SUSPECT;
          end
        end
        SUSPECT: begin
          if (mismatch) begin
            cnt_next = cnt_inc;
            if (cnt_inc >= THRESH && exclude_allow) begin
              state_next = FAULTY;
            end
          end else begin
            state_next = HEALTHY;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = state_q;
        end
      endcase
    end
  end

  // A suspect replica still votes; only FAULTY removes it
  always_comb begin
    healthy = (state_q != FAULTY);
  end

endmodule

// File: rtl/cv32e40p_nmr_voter.sv
// Registered N-modular-redundancy word voter with per-replica fault tracking.
// Votes over healthy replicas only and degrades NMR -> DUPLEX -> SIMPLEX as
// replicas are excluded. Optional macro CV32E40P_VOTER_STATS_EN adds
// saturating totals of corrected and uncorrectable beats.
module cv32e40p_nmr_voter
  import cv32e40p_nmr_pkg::*;
#(
  parameter int LEN          = 32,
  parameter int N_REP        = 3,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [N_REP*LEN-1:0] in_i,
  input  logic [N_REP-1:0]     reinstate_i,
  output logic                 valid_o,
  output logic [LEN-1:0]       voted_o,
  output logic                 error_correct_o,
  output logic                 error_detected_o,
  output logic                 uncorrectable_o,
  output logic [N_REP-1:0]     healthy_o,
  output logic [1:0]           mode_o
`ifdef CV32E40P_VOTER_STATS_EN
  ,
  output logic [STATS_W-1:0]   corr_cnt_o,
  output logic [STATS_W-1:0]   uncorr_cnt_o
`endif
);

  localparam int AW = 4;
  localparam int IW = $clog2(N_REP);

  logic [LEN-1:0]   word [N_REP];
  logic [AW-1:0]    agree [N_REP];
  logic [AW-1:0]    h_cnt;
  logic [N_REP-1:0] healthy;
  logic [N_REP-1:0] low_onehot;
  logic [N_REP-1:0] mismatch;
  logic [N_REP-1:0] exclude_allow;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    low_idx;
  logic             win_found;
  logic             detected;
  logic             all_mismatch;
  logic             beat_en;
  logic [LEN-1:0]   voted;
  mode_e            mode;

  // Unpack the replica bus into an indexable array
  always_comb begin
    for (int k = 0; k < N_REP; k++) begin
      word[k] = in_i[k*LEN +: LEN];
    end
  end

  // Count healthy replicas
  always_comb begin
    h_cnt = '0;
    for (int k = 0; k < N_REP; k++) begin
      if (healthy[k]) h_cnt = h_cnt + AW'(1);
    end
  end

  // For every replica, count the healthy replicas carrying the same word
  always_comb begin
    for (int i = 0; i < N_REP; i++) begin
      agree[i] = '0;
      for (int j = 0; j < N_REP; j++) begin
        if (healthy[j] && (word[j] == word[i])) agree[i] = agree[i] + AW'(1);
      end
    end
  end

  // Pick the lowest healthy strict-majority replica and the lowest healthy replica
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    low_idx   = '0;
    for (int i = N_REP - 1; i >= 0; i--) begin
      if (healthy[i]) low_idx = IW'(i);
      if (healthy[i] && ((agree[i] << 1) > h_cnt)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  // Voted word, disagreement detection and per-replica mismatch for the trackers
  always_comb begin
    voted    = win_found ? word[win_idx] : word[low_idx];
    detected = 1'b0;
    for (int k = 0; k < N_REP; k++) begin
      if (healthy[k] && (word[k] != word[low_idx])) detected = 1'b1;
      mismatch[k] = win_found && healthy[k] && (word[k] != voted);
    end
  end

  // Keep the lowest healthy replica if every healthy one would otherwise be excluded
  always_comb begin
    low_onehot    = healthy & (~healthy + N_REP'(1));
    all_mismatch  = &(mismatch | ~healthy);
    exclude_allow = ~(low_onehot & {N_REP{all_mismatch}});
    beat_en       = valid_i && win_found;
  end

  for (genvar k = 0; k < N_REP; k++) begin : g_health
    cv32e40p_nmr_health #(
      .FAULT_THRESH(FAULT_THRESH),
      .CNT_W       (CNT_W)
    ) u_health (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .mismatch     (mismatch[k]),
      .beat_en      (beat_en),
      .reinstate    (reinstate_i[k]),
      .exclude_allow(exclude_allow[k]),
      .healthy      (healthy[k])
    );
  end

  // Redundancy level follows the registered healthy mask
  always_comb begin
    if (h_cnt >= AW'(3))      mode = NMR;
    else if (h_cnt == AW'(2)) mode = DUPLEX;
    else                      mode = SIMPLEX;
  end

  assign healthy_o = healthy;
  assign mode_o    = mode;

  // Output stage: one cycle of latency, word and flags hold across idle cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o          <= 1'b0;
      voted_o          <= '0;
      error_correct_o  <= 1'b0;
      error_detected_o <= 1'b0;
      uncorrectable_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        voted_o          <= voted;
        error_correct_o  <= win_found && detected;
        error_detected_o <= detected;
        uncorrectable_o  <= !win_found;
      end
    end
  end

`ifdef CV32E40P_VOTER_STATS_EN
  // Saturating totals, counted from the registered flags of each valid beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else begin
      if (valid_o && error_correct_o && (corr_cnt_o != '1)) begin
        corr_cnt_o <= corr_cnt_o + STATS_W'(1);
      end
      if (valid_o && uncorrectable_o && (uncorr_cnt_o != '1)) begin
        uncorr_cnt_o <= uncorr_cnt_o + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_nmr_voter.sv
// Self-checking bench for cv32e40p_nmr_voter: a 3-replica and a 5-replica
// instance, directed scenarios followed by randomized beats, all compared
// against a behavioural vote / fault-history model.
module tb_cv32e40p_nmr_voter;

  localparam int THRESH  = 4;
  localparam int CNT_MAX = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] word_in [2][5];
  logic        val_in [2];
  logic [4:0]  rein [2];
  logic [95:0]  in3;
  logic [159:0] in5;

  logic        v3, ec3, ed3, un3;
  logic [31:0] vo3;
  logic [2:0]  h3;
  logic [1:0]  m3;
  logic        v5, ec5, ed5, un5;
  logic [31:0] vo5;
  logic [4:0]  h5;
  logic [1:0]  m5;
`ifdef CV32E40P_VOTER_STATS_EN
  logic [15:0] cc3, uc3, cc5, uc5;
`endif

  int errors = 0;
  int checks = 0;

  int          streak [2][5];
  bit          oos [2][5];
  logic        exp_valid [2];
  logic [31:0] exp_voted [2];
  logic        exp_ec [2];
  logic        exp_ed [2];
  logic        exp_unc [2];
  logic [4:0]  exp_healthy [2];
  logic [1:0]  exp_mode [2];

  // Pack replica words onto the DUT buses
  always_comb begin
    in3 = {word_in[0][2], word_in[0][1], word_in[0][0]};
    in5 = {word_in[1][4], word_in[1][3], word_in[1][2], word_in[1][1], word_in[1][0]};
  end

  cv32e40p_nmr_voter #(.LEN(32), .N_REP(3), .FAULT_THRESH(THRESH), .CNT_W(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .valid_i(val_in[0]), .in_i(in3), .reinstate_i(rein[0][2:0]),
    .valid_o(v3), .voted_o(vo3), .error_correct_o(ec3), .error_detected_o(ed3),
    .uncorrectable_o(un3), .healthy_o(h3), .mode_o(m3)
`ifdef CV32E40P_VOTER_STATS_EN
    , .corr_cnt_o(cc3), .uncorr_cnt_o(uc3)
`endif
  );

  cv32e40p_nmr_voter #(.LEN(32), .N_REP(5), .FAULT_THRESH(THRESH), .CNT_W(3)) dut5 (
    .clk_i(clk), .rst_i(rst), .valid_i(val_in[1]), .in_i(in5), .reinstate_i(rein[1]),
    .valid_o(v5), .voted_o(vo5), .error_correct_o(ec5), .error_detected_o(ed5),
    .uncorrectable_o(un5), .healthy_o(h5), .mode_o(m5)
`ifdef CV32E40P_VOTER_STATS_EN
    , .corr_cnt_o(cc5), .uncorr_cnt_o(uc5)
`endif
  );

  task automatic cmp(input string tag, input string item, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s observed=%h expected=%h", tag, item, obs, exp);
    end
  endtask

  // Reference model: applies one clock edge worth of behaviour to unit u
  task automatic modelEdge(input int u, input bit r);
    int n, h, low, win, a, kept;
    bit det;
    bit cand [5];
    logic [31:0] v;
    n = (u == 0) ? 3 : 5;
    if (r) begin
      exp_valid[u] = 1'b0;
      exp_voted[u] = '0;
      exp_ec[u] = 1'b0;
      exp_ed[u] = 1'b0;
      exp_unc[u] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        streak[u][k] = 0;
        oos[u][k] = 1'b0;
      end
    end else begin
      exp_valid[u] = val_in[u];
      if (val_in[u]) begin
        h = 0;
        low = -1;
        for (int i = 0; i < n; i++) begin
          if (!oos[u][i]) begin
            h++;
            if (low < 0) low = i;
          end
        end
        win = -1;
        for (int i = 0; i < n; i++) begin
          if (!oos[u][i] && win < 0) begin
            a = 0;
            for (int j = 0; j < n; j++)
              if (!oos[u][j] && word_in[u][j] == word_in[u][i]) a++;
            if (2 * a > h) win = i;
          end
        end
        det = 1'b0;
        for (int i = 0; i < n; i++)
          if (!oos[u][i] && word_in[u][i] != word_in[u][low]) det = 1'b1;
        v = (win >= 0) ? word_in[u][win] : word_in[u][low];
        exp_voted[u] = v;
        exp_ed[u] = det;
        exp_ec[u] = (win >= 0) && det;
        exp_unc[u] = (win < 0);
        if (win >= 0) begin
          kept = 0;
          for (int k = 0; k < n; k++) begin
            cand[k] = 1'b0;
            if (!oos[u][k]) begin
              if (word_in[u][k] != v) begin
                if (streak[u][k] < CNT_MAX) streak[u][k]++;
                if (streak[u][k] >= THRESH) cand[k] = 1'b1;
                else kept++;
              end else begin
                streak[u][k] = 0;
                kept++;
              end
            end
          end
          for (int k = 0; k < n; k++) begin
            if (cand[k]) begin
              if (kept == 0) kept = 1;
              else oos[u][k] = 1'b1;
            end
          end
        end
      end
      for (int k = 0; k < n; k++) begin
        if (rein[u][k]) begin
          oos[u][k] = 1'b0;
          streak[u][k] = 0;
        end
      end
    end
    h = 0;
    exp_healthy[u] = '0;
    for (int k = 0; k < n; k++) begin
      if (!oos[u][k]) begin
        exp_healthy[u][k] = 1'b1;
        h++;
      end
    end
    exp_mode[u] = (h >= 3) ? 2'b00 : ((h == 2) ? 2'b01 : 2'b10);
  endtask

  // One clock: sample on the edge, advance the model, settle, then check both units
  task automatic applyStimulus(input bit r, input string tag);
    rst = r;
    @(posedge clk);
    modelEdge(0, r);
    modelEdge(1, r);
    #1;
    checkOutput(tag, 0);
    checkOutput(tag, 1);
  endtask

  task automatic checkOutput(input string tag, input int u);
    if (u == 0) begin
      cmp(tag, "u3.valid_o", {31'b0, v3}, {31'b0, exp_valid[0]});
      cmp(tag, "u3.voted_o", vo3, exp_voted[0]);
      cmp(tag, "u3.error_correct_o", {31'b0, ec3}, {31'b0, exp_ec[0]});
      cmp(tag, "u3.error_detected_o", {31'b0, ed3}, {31'b0, exp_ed[0]});
      cmp(tag, "u3.uncorrectable_o", {31'b0, un3}, {31'b0, exp_unc[0]});
      cmp(tag, "u3.healthy_o", {29'b0, h3}, {27'b0, exp_healthy[0]});
      cmp(tag, "u3.mode_o", {30'b0, m3}, {30'b0, exp_mode[0]});
    end else begin
      cmp(tag, "u5.valid_o", {31'b0, v5}, {31'b0, exp_valid[1]});
      cmp(tag, "u5.voted_o", vo5, exp_voted[1]);
      cmp(tag, "u5.error_correct_o", {31'b0, ec5}, {31'b0, exp_ec[1]});
      cmp(tag, "u5.error_detected_o", {31'b0, ed5}, {31'b0, exp_ed[1]});
      cmp(tag, "u5.uncorrectable_o", {31'b0, un5}, {31'b0, exp_unc[1]});
      cmp(tag, "u5.healthy_o", {27'b0, h5}, {27'b0, exp_healthy[1]});
      cmp(tag, "u5.mode_o", {30'b0, m5}, {30'b0, exp_mode[1]});
    end
  endtask

  task automatic set3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    word_in[0][0] = a;
    word_in[0][1] = b;
    word_in[0][2] = c;
    val_in[0] = 1'b1;
  endtask

  task automatic set5(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input logic [31:0] e);
    word_in[1][0] = a;
    word_in[1][1] = b;
    word_in[1][2] = c;
    word_in[1][3] = d;
    word_in[1][4] = e;
    val_in[1] = 1'b1;
  endtask

  initial begin
    logic [31:0] base, alt;
    int sick [2];
    int n, r;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 5; k++) word_in[u][k] = '0;
      val_in[u] = 1'b0;
      rein[u] = '0;
    end

    $display("[TB] reset");
    applyStimulus(1'b1, "reset");
    applyStimulus(1'b1, "reset");
    cmp("reset", "healthy3", {29'b0, h3}, 32'h7);
    cmp("reset", "valid3", {31'b0, v3}, 32'h0);

    $display("[TB] all replicas agree");
    set3(32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000);
    applyStimulus(1'b0, "agree");
    cmp("agree", "voted3", vo3, 32'hA5A5_0000);
    cmp("agree", "flags3", {29'b0, ec3, ed3, un3}, 32'h0);

    $display("[TB] replica 2 stuck, excluded after threshold");
    for (int b = 0; b < 4; b++) begin
      set3(32'h1234, 32'h1234, 32'hFFFF_FFFF);
      applyStimulus(1'b0, "stuck2");
      cmp("stuck2", "ec3", {31'b0, ec3}, 32'h1);
    end
    cmp("stuck2", "healthy3_after4", {29'b0, h3}, 32'h3);
    set3(32'h1234, 32'h1234, 32'hFFFF_FFFF);
    applyStimulus(1'b0, "duplex_agree");
    cmp("duplex_agree", "mode3", {30'b0, m3}, 32'h1);
    cmp("duplex_agree", "ed3", {31'b0, ed3}, 32'h0);

    $display("[TB] duplex disagreement");
    set3(32'h1, 32'h2, 32'hFFFF_FFFF);
    applyStimulus(1'b0, "duplex_dis");
    cmp("duplex_dis", "unc3", {31'b0, un3}, 32'h1);
    cmp("duplex_dis", "voted3", vo3, 32'h1);
    set3(32'h5, 32'h5, 32'h0);
    applyStimulus(1'b0, "duplex_ok");

    $display("[TB] reinstate replica 2");
    val_in[0] = 1'b0;
    rein[0] = 5'b00100;
    applyStimulus(1'b0, "reinstate");
    rein[0] = '0;
    cmp("reinstate", "healthy3", {29'b0, h3}, 32'h7);

    $display("[TB] suspect recovers on a matching beat");
    for (int b = 0; b < 3; b++) begin
      set3(32'h8, 32'h9, 32'h8);
      applyStimulus(1'b0, "suspect");
    end
    set3(32'h8, 32'h8, 32'h8);
    applyStimulus(1'b0, "recover");
    for (int b = 0; b < 3; b++) begin
      set3(32'h8, 32'h9, 32'h8);
      applyStimulus(1'b0, "suspect2");
    end
    cmp("suspect2", "healthy3", {29'b0, h3}, 32'h7);
    set3(32'h8, 32'h9, 32'h8);
    applyStimulus(1'b0, "fault1");
    cmp("fault1", "healthy3", {29'b0, h3}, 32'h5);

    $display("[TB] reset while streaming with replica 0 faulty");
    val_in[0] = 1'b0;
    rein[0] = 5'b00111;
    applyStimulus(1'b0, "rein_all");
    rein[0] = '0;
    for (int b = 0; b < 4; b++) begin
      set3(32'h6, 32'h7, 32'h7);
      applyStimulus(1'b0, "fault0");
    end
    cmp("fault0", "healthy3", {29'b0, h3}, 32'h6);
    set3(32'h7, 32'h7, 32'h7);
    applyStimulus(1'b0, "stream");
    applyStimulus(1'b1, "midreset");
    cmp("midreset", "valid3", {31'b0, v3}, 32'h0);
    cmp("midreset", "healthy3", {29'b0, h3}, 32'h7);

    $display("[TB] reinstate on the threshold beat");
    for (int b = 0; b < 3; b++) begin
      set3(32'h3, 32'h3, 32'h4);
      applyStimulus(1'b0, "pre_thresh");
    end
    set3(32'h3, 32'h3, 32'h4);
    rein[0] = 5'b00100;
    applyStimulus(1'b0, "rein_thresh");
    rein[0] = '0;
    cmp("rein_thresh", "healthy3", {29'b0, h3}, 32'h7);
    set3(32'h3, 32'h3, 32'h4);
    applyStimulus(1'b0, "after_rein");
    val_in[0] = 1'b0;

    $display("[TB] five replicas");
    set5(32'd7, 32'd7, 32'd7, 32'd9, 32'd3);
    applyStimulus(1'b0, "n5_maj");
    cmp("n5_maj", "voted5", vo5, 32'd7);
    cmp("n5_maj", "ec5", {31'b0, ec5}, 32'h1);
    set5(32'd7, 32'd7, 32'd9, 32'd9, 32'd3);
    applyStimulus(1'b0, "n5_tie");
    cmp("n5_tie", "unc5", {31'b0, un5}, 32'h1);
    cmp("n5_tie", "voted5", vo5, 32'd7);

    $display("[TB] randomized beats");
    sick[0] = 2;
    sick[1] = 4;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        n = (u == 0) ? 3 : 5;
        if ($urandom_range(0, 39) == 0) sick[u] = $urandom_range(0, n - 1);
        base = $urandom;
        alt = base ^ 32'h1;
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(0, 19);
          if ((k == sick[u] && r < 15) || r < 2)
            word_in[u][k] = ($urandom_range(0, 1) == 1) ? alt : $urandom;
          else
            word_in[u][k] = base;
        end
        val_in[u] = ($urandom_range(0, 7) != 0);
        rein[u] = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
        if (u == 0) rein[u][4:3] = 2'b00;
      end
      applyStimulus(($urandom_range(0, 249) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
